instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/instruction_fetch_pc_register.sv | 26 ++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction classes, fetch FSM states and the NOP encoding.
package rv32i_pkg;

  typedef enum logic [3:0] {
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_IMM,
    OP_REG,
    OP_FENCE,
    OP_SYSTEM,
    OP_ILLEGAL
  } op_type_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_FAULT
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register with its +4 adder; pc_plus4 wraps modulo 2^32.
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one read per instruction, holds IR until execute is done.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-target fault and the fault port.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = rv32i_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  fetch_state_t state_q, state_d;
  logic         pc_load;
  logic [31:0]  pc_load_val;
  logic         ir_load;
  logic [31:0]  ir_q;
  logic         ir_valid_q;
  logic [31:0]  fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         fault_set;
  logic         fault_q;
`endif

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (pc_load_val),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  assign pc_load_val = align_word(next_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Responses outside S_WAIT and redirects outside S_EXEC fall through untouched.
  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    pc_load    = 1'b0;
    ir_load    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_set  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_rd_req = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        mem_rd_req = 1'b1;
        if (mem_rd_valid) begin
          ir_load = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (next_pc_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (is_word_aligned(next_pc)) begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end else begin
            fault_set = 1'b1;
            state_d   = S_FAULT;
          end
`else
          pc_load = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_FAULT: begin
`ifdef FETCH_ALIGN_CHECK_EN
        state_d = S_FAULT;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ir_valid is registered so it lines up with the first S_EXEC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q          <= NOP_INSN;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      ir_valid_q <= ir_load;
      if (ir_load) begin
        ir_q          <= mem_rd_data;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`endif

  assign mem_addr    = pc;
  assign IR          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; inputs change and outputs are sampled on the falling edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic [31:0] fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  int checks;
  int failures;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INSN(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .IR           (IR),
    .ir_valid     (ir_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .next_pc_valid(next_pc_valid),
    .next_pc      (next_pc),
    .fetch_count  (fetch_count)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fault        (fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd_valid, input logic [31:0] rd_data,
                               input logic npc_valid, input logic [31:0] npc);
    mem_rd_valid  = rd_valid;
    mem_rd_data   = rd_data;
    next_pc_valid = npc_valid;
    next_pc       = npc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_pc", pc, 32'h0000_0000);
    checkOutput("rst_ir", IR, 32'h0000_0013);
    checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rst_fault", 32'(fault), 32'd0);
`endif

    // First fetch after reset release, zero-wait memory
    rst = 1'b1;
    checkOutput("f1_req", 32'(mem_rd_req), 32'd1);
    checkOutput("f1_addr", mem_addr, 32'h0000_0000);
    tick();
    checkOutput("w1_req", 32'(mem_rd_req), 32'd1);
    applyStimulus(1'b1, 32'h0050_0093, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("e1_ir_valid", 32'(ir_valid), 32'd1);
    checkOutput("e1_ir", IR, 32'h0050_0093);
    checkOutput("e1_pc", pc, 32'h0000_0000);
    checkOutput("e1_count", fetch_count, 32'd1);
    checkOutput("e1_req", 32'(mem_rd_req), 32'd0);
    tick();
    checkOutput("e1_pulse_end", 32'(ir_valid), 32'd0);

    // Spurious response while executing
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("spur_ir", IR, 32'h0050_0093);
    checkOutput("spur_count", fetch_count, 32'd1);
    checkOutput("spur_ir_valid", 32'(ir_valid), 32'd0);

    // Redirect to 0x40
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0040);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("j40_req", 32'(mem_rd_req), 32'd1);
    checkOutput("j40_addr", mem_addr, 32'h0000_0040);
    checkOutput("j40_pc4", pc_plus4, 32'h0000_0044);
    tick();

    // Five wait cycles with no response, a stray redirect in the middle
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("wait%0d_req", i), 32'(mem_rd_req), 32'd1);
      checkOutput($sformatf("wait%0d_addr", i), mem_addr, 32'h0000_0040);
      checkOutput($sformatf("wait%0d_irv", i), 32'(ir_valid), 32'd0);
      if (i == 2) applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0100);
      else        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    checkOutput("wait5_req", 32'(mem_rd_req), 32'd1);
    checkOutput("wait5_addr", mem_addr, 32'h0000_0040);
    checkOutput("wait5_count", fetch_count, 32'd1);
    applyStimulus(1'b1, 32'h00A0_0113, 1'b0, 32'h0);
    tick();
    // Redirect on the same cycle as the ir_valid pulse, to the top word
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("e2_ir_valid", 32'(ir_valid), 32'd1);
    checkOutput("e2_ir", IR, 32'h00A0_0113);
    checkOutput("e2_pc", pc, 32'h0000_0040);
    checkOutput("e2_count", fetch_count, 32'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("top_irv", 32'(ir_valid), 32'd0);
    checkOutput("top_req", 32'(mem_rd_req), 32'd1);
    checkOutput("top_addr", mem_addr, 32'hFFFF_FFFC);
    checkOutput("top_pc4", pc_plus4, 32'h0000_0000);
    tick();
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("e3_ir", IR, 32'h1111_1111);
    checkOutput("e3_pc", pc, 32'hFFFF_FFFC);
    checkOutput("e3_count", fetch_count, 32'd3);

    // Misaligned redirect
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0042);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis_fault", 32'(fault), 32'd1);
    checkOutput("mis_req", 32'(mem_rd_req), 32'd0);
    checkOutput("mis_pc", pc, 32'hFFFF_FFFC);
    tick();
    tick();
    checkOutput("mis_fault_sticky", 32'(fault), 32'd1);
    checkOutput("mis_req_later", 32'(mem_rd_req), 32'd0);
`else
    checkOutput("mis_req", 32'(mem_rd_req), 32'd1);
    checkOutput("mis_addr", mem_addr, 32'h0000_0040);
    checkOutput("mis_pc", pc, 32'h0000_0040);
`endif

    // Fresh reset, then reset again in the middle of S_WAIT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("w_before_rst_req", 32'(mem_rd_req), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_ir", IR, 32'h0000_0013);
    checkOutput("midrst_pc", pc, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("late_ir", IR, 32'h0000_0013);
    checkOutput("late_count", fetch_count, 32'd0);
    checkOutput("late_pc", pc, 32'h0000_0000);
    checkOutput("late_irv", 32'(ir_valid), 32'd0);
    checkOutput("late_req", 32'(mem_rd_req), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("late_fault", 32'(fault), 32'd0);
`endif
    tick();
    checkOutput("late_still_wait", 32'(ir_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
